mem_512x8_fifo_ctrl: RTL and testbench

- Synchronous FIFO controller that sequences one dpram_512x8 primitive as a 512-entry, 8-bit queue.
- Owns the write/read pointers, occupancy count, status flags and error flags.
- Drives the RAM's waddr/raddr/data_in/wen/ren and returns its data_out to the consumer.
- Sits in the memory-mode tile wrapper, between fabric-side push/pop logic and the RAM instance.

---
 rtl/mem_fifo_pkg.sv | 9 +
 rtl/mem_fifo_ptr.sv | 19 +
 rtl/mem_512x8_fifo_ctrl.sv | 104 ++++++++++
 tb/tb_mem_512x8_fifo_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_fifo_pkg.sv
// Shared constants for the 512x8 memory-mode FIFO controller.
// The defaults describe the dpram_512x8 primitive this controller sequences.
package mem_fifo_pkg;
  localparam int MEM_ADDR_W    = 9;
  localparam int MEM_DATA_W    = 8;
  localparam int MEM_DEPTH     = 512;
  localparam int AFULL_TH_DEF  = 480;
  localparam int AEMPTY_TH_DEF = 32;
endpackage

// File: rtl/mem_fifo_ptr.sv
// Wrapping RAM address pointer with enable and synchronous clear.
// There is no extra wrap bit; the controller's occupancy count tells full from empty.
module mem_fifo_ptr #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  output logic [ADDR_W-1:0] ptr
);
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= ptr + 1'b1;
    end
  end
endmodule

// File: rtl/mem_512x8_fifo_ctrl.sv
// FIFO controller that runs one external dpram_512x8 as a 512-entry queue.
// Owns pointers, occupancy, status flags and sticky error flags.
module mem_512x8_fifo_ctrl
  import mem_fifo_pkg::*;
#(
  parameter int ADDR_W    = MEM_ADDR_W,
  parameter int DATA_W    = MEM_DATA_W,
  parameter int AFULL_TH  = AFULL_TH_DEF,
  parameter int AEMPTY_TH = AEMPTY_TH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              pop_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [ADDR_W-1:0] ram_raddr,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_wen,
  output logic              ram_ren,
  input  logic [DATA_W-1:0] ram_data_out
);
  localparam logic [ADDR_W:0] DEPTH_C   = (ADDR_W+1)'(1 << ADDR_W);
  localparam logic [ADDR_W:0] AFULL_C   = (ADDR_W+1)'(AFULL_TH);
  localparam logic [ADDR_W:0] AEMPTY_C  = (ADDR_W+1)'(AEMPTY_TH);

  // Handshake: push/pop are requests, taken only when the registered full/empty
  // flag allows and no flush is active; pop_valid qualifies pop_data exactly one
  // cycle after an accepted pop, because the RAM read is registered.
  logic              push_acc;
  logic              pop_acc;
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [ADDR_W:0]   count_next;

  assign push_acc = push & ~full & ~flush;
  assign pop_acc  = pop & ~empty & ~flush;

  assign ram_wen     = push_acc;
  assign ram_waddr   = wptr;
  assign ram_data_in = push_data;
  assign ram_ren     = pop_acc;
  assign ram_raddr   = rptr;
  assign pop_data    = ram_data_out;

  assign count_next = count + {{ADDR_W{1'b0}}, push_acc} - {{ADDR_W{1'b0}}, pop_acc};

  mem_fifo_ptr #(.ADDR_W(ADDR_W)) u_wptr (
    .clk   (clk),
    .reset (reset),
    .clr   (flush),
    .en    (push_acc),
    .ptr   (wptr)
  );

  mem_fifo_ptr #(.ADDR_W(ADDR_W)) u_rptr (
    .clk   (clk),
    .reset (reset),
    .clr   (flush),
    .en    (pop_acc),
    .ptr   (rptr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
      pop_valid    <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      pop_valid <= pop_acc;
      // Error flags survive flush; only reset clears them.
      if (push && full)  overflow  <= 1'b1;
      if (pop && empty)  underflow <= 1'b1;
      if (flush) begin
        count        <= '0;
        empty        <= 1'b1;
        full         <= 1'b0;
        almost_empty <= 1'b1;
        almost_full  <= 1'b0;
      end else begin
        count        <= count_next;
        empty        <= (count_next == '0);
        full         <= (count_next == DEPTH_C);
        almost_empty <= (count_next <= AEMPTY_C);
        almost_full  <= (count_next >= AFULL_C);
      end
    end
  end
endmodule

// File: tb/tb_mem_512x8_fifo_ctrl.sv
// Bench for mem_512x8_fifo_ctrl: directed plan scenarios plus randomized traffic,
// checked every cycle against a queue-based model of the FIFO.
module tb_mem_512x8_fifo_ctrl;
  localparam int DEPTH = 512;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       flush = 1'b0;
  logic       push = 1'b0;
  logic [7:0] push_data = 8'h00;
  logic       pop = 1'b0;
  logic [7:0] pop_data;
  logic       pop_valid, full, empty, almost_full, almost_empty;
  logic [9:0] count;
  logic       overflow, underflow;
  logic [8:0] ram_waddr, ram_raddr;
  logic [7:0] ram_data_in;
  logic       ram_wen, ram_ren;
  logic [7:0] ram_data_out = 8'h00;

  mem_512x8_fifo_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .push         (push),
    .push_data    (push_data),
    .pop          (pop),
    .pop_data     (pop_data),
    .pop_valid    (pop_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow),
    .ram_waddr    (ram_waddr),
    .ram_raddr    (ram_raddr),
    .ram_data_in  (ram_data_in),
    .ram_wen      (ram_wen),
    .ram_ren      (ram_ren),
    .ram_data_out (ram_data_out)
  );

  // dpram_512x8 stand-in: synchronous write, one-cycle registered read
  logic [7:0] ram_mem [DEPTH];
  always @(posedge clk) begin
    if (ram_wen) ram_mem[ram_waddr] <= ram_data_in;
    if (ram_ren) ram_data_out <= ram_mem[ram_raddr];
  end

  // scoreboard / behavioural model
  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  int m_wp = 0, m_rp = 0;
  bit m_ov = 0, m_uf = 0, m_valid = 0;
  logic [7:0] m_data = 8'h00;
  bit mon_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    bit pa, po;
    if (reset) begin
      exp_q.delete();
      m_wp = 0; m_rp = 0; m_ov = 0; m_uf = 0; m_valid = 0;
    end else begin
      if (push && exp_q.size() == DEPTH) m_ov = 1;
      if (pop && exp_q.size() == 0) m_uf = 1;
      if (flush) begin
        exp_q.delete();
        m_wp = 0; m_rp = 0; m_valid = 0;
      end else begin
        pa = push && (exp_q.size() < DEPTH);
        po = pop && (exp_q.size() > 0);
        m_valid = po;
        if (po) begin
          m_data = exp_q.pop_front();
          m_rp = (m_rp + 1) % DEPTH;
        end
        if (pa) begin
          exp_q.push_back(push_data);
          m_wp = (m_wp + 1) % DEPTH;
        end
      end
    end
  end

  always @(negedge clk) begin
    bit e_wen, e_ren;
    int n;
    if (mon_en) begin
      n = exp_q.size();
      chk("count", 32'(count), 32'(n));
      chk("full", 32'(full), 32'(n == DEPTH));
      chk("empty", 32'(empty), 32'(n == 0));
      chk("almost_full", 32'(almost_full), 32'(n >= 480));
      chk("almost_empty", 32'(almost_empty), 32'(n <= 32));
      chk("overflow", 32'(overflow), 32'(m_ov));
      chk("underflow", 32'(underflow), 32'(m_uf));
      chk("pop_valid", 32'(pop_valid), 32'(m_valid));
      if (m_valid) chk("pop_data", 32'(pop_data), 32'(m_data));
      e_wen = push && (n < DEPTH) && !flush;
      e_ren = pop && (n > 0) && !flush;
      chk("ram_wen", 32'(ram_wen), 32'(e_wen));
      chk("ram_ren", 32'(ram_ren), 32'(e_ren));
      if (e_wen) begin
        chk("ram_waddr", 32'(ram_waddr), 32'(m_wp));
        chk("ram_data_in", 32'(ram_data_in), 32'(push_data));
      end
      if (e_ren) chk("ram_raddr", 32'(ram_raddr), 32'(m_rp));
    end
  end

  // driver tasks
  task automatic set_in(input bit p, input logic [7:0] d, input bit po, input bit f);
    push = p; push_data = d; pop = po; flush = f;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_in(0, 8'h00, 0, 0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    do_reset();
    mon_en = 1;
    // reset state
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_aempty", 32'(almost_empty), 32'd1);
    chk("rst_pop_valid", 32'(pop_valid), 32'd0);

    // three pushes, three pops
    set_in(1, 8'h11, 0, 0); #1 chk("t1_waddr0", 32'(ram_waddr), 32'd0); tick();
    set_in(1, 8'h22, 0, 0); #1 chk("t1_waddr1", 32'(ram_waddr), 32'd1); tick();
    set_in(1, 8'h33, 0, 0); #1 chk("t1_waddr2", 32'(ram_waddr), 32'd2); tick();
    chk("t1_count3", 32'(count), 32'd3);
    set_in(0, 8'h00, 1, 0); tick();
    chk("t1_data0", 32'(pop_data), 32'h11);
    tick();
    chk("t1_data1", 32'(pop_data), 32'h22);
    tick();
    chk("t1_data2", 32'(pop_data), 32'h33);
    chk("t1_valid2", 32'(pop_valid), 32'd1);
    chk("t1_count0", 32'(count), 32'd0);
    chk("t1_empty", 32'(empty), 32'd1);
    set_in(0, 8'h00, 0, 0); tick();
    chk("t1_valid_off", 32'(pop_valid), 32'd0);

    // fill to full, then overflow
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      set_in(1, 8'(i), 0, 0);
      tick();
      if (i == 478 || i == 479)
        chk("t2_afull_edge", 32'(almost_full), 32'(i + 1 >= 480));
    end
    chk("t2_full", 32'(full), 32'd1);
    chk("t2_count512", 32'(count), 32'd512);
    set_in(1, 8'hFF, 0, 0); #1 chk("t2_wen_full", 32'(ram_wen), 32'd0); tick();
    chk("t2_overflow", 32'(overflow), 32'd1);

    // push and pop together while full
    set_in(1, 8'hEE, 1, 0); tick();
    chk("t3_valid", 32'(pop_valid), 32'd1);
    chk("t3_data", 32'(pop_data), 32'h00);
    chk("t3_count511", 32'(count), 32'd511);
    chk("t3_overflow", 32'(overflow), 32'd1);

    // streaming through the pointer wrap
    do_reset();
    set_in(1, 8'($urandom), 0, 0); tick();
    for (int i = 0; i < 600; i++) begin
      set_in(1, 8'($urandom), 1, 0);
      tick();
    end
    chk("t4_count1", 32'(count), 32'd1);

    // push and pop together while empty
    do_reset();
    set_in(1, 8'hA5, 1, 0); tick();
    chk("t5_no_valid", 32'(pop_valid), 32'd0);
    chk("t5_underflow", 32'(underflow), 32'd1);
    chk("t5_count1", 32'(count), 32'd1);
    set_in(0, 8'h00, 1, 0); tick();
    chk("t5_data", 32'(pop_data), 32'hA5);

    // pop then flush
    do_reset();
    for (int i = 0; i < 10; i++) begin
      set_in(1, 8'(i + 8'h40), 0, 0);
      tick();
    end
    set_in(0, 8'h00, 1, 0); tick();
    set_in(0, 8'h00, 0, 1);
    #1 chk("t6_valid_in_flush", 32'(pop_valid), 32'd1);
    chk("t6_data_in_flush", 32'(pop_data), 32'h40);
    tick();
    chk("t6_count0", 32'(count), 32'd0);
    chk("t6_empty", 32'(empty), 32'd1);
    chk("t6_valid_off", 32'(pop_valid), 32'd0);
    set_in(1, 8'h77, 0, 0); #1 chk("t6_waddr0", 32'(ram_waddr), 32'd0); tick();

    // randomized traffic in push-heavy / pop-heavy phases
    for (int ph = 0; ph < 8; ph++) begin
      int pw;
      pw = (ph % 2 == 0) ? 85 : 20;
      for (int i = 0; i < 700; i++) begin
        set_in($urandom_range(99) < pw, 8'($urandom), $urandom_range(99) < (100 - pw),
               $urandom_range(299) == 0);
        reset = ($urandom_range(999) == 0);
        tick();
      end
    end
    reset = 1'b0;
    set_in(0, 8'h00, 0, 0);
    tick();
    tick();
    mon_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
